// File: rtl/inst_sram_resp.sv
// Instruction-side SRAM responder: word array with WAIT_CYC wait states and a fetch stall request.
// Optional write port is enabled by defining INST_SRAM_WRITE_EN.
module inst_sram_resp #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned WAIT_CYC   = 0,
    parameter logic [31:0] BASE_PADDR = 32'h1FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_rvalid,
    output logic        inst_sram_stallreq,
    output logic        inst_sram_err
);

`ifdef INST_SRAM_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_idx_q, lat_idx_d;
    logic                lat_rng_q, lat_rng_d;

    logic [31:0]         mem [DEPTH];

    logic [31:0]         paddr;
    logic [31:0]         offs;
    logic                in_range;
    logic [ADDR_W-1:0]   idx;

    logic                rd_fire;
    logic [ADDR_W-1:0]   rd_idx;
    logic                rd_rng;
    logic                wr_fire;
    logic                stall_raw;

    // Strip kseg0/kseg1 segment bits, then rebase onto word 0.
    assign paddr    = {3'b000, inst_sram_addr[28:0]};
    assign offs     = paddr - BASE_PADDR;
    assign in_range = (offs >> (ADDR_W + 2)) == 32'd0;
    assign idx      = offs[ADDR_W+1:2];

    logic unused_bits;
    assign unused_bits = ^{inst_sram_addr[31:29], offs[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_idx_d = lat_idx_q;
        lat_rng_d = lat_rng_q;
        rd_fire   = 1'b0;
        rd_idx    = idx;
        rd_rng    = in_range;
        wr_fire   = 1'b0;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inst_sram_en) begin
                    if (inst_sram_wen == 4'b0000) begin
                        if (WAIT_CYC == 0) begin
                            rd_fire = 1'b1;
                        end else begin
                            state_d   = StWait;
                            cnt_d     = CNT_INIT;
                            lat_idx_d = idx;
                            lat_rng_d = in_range;
                            stall_raw = 1'b1;
                        end
                    end else begin
                        wr_fire = 1'b1;
                    end
                end
            end
            StWait: begin
                rd_idx = lat_idx_q;
                rd_rng = lat_rng_q;
                if (cnt_q != 4'd0) begin
                    cnt_d     = cnt_q - 4'd1;
                    stall_raw = 1'b1;
                end else begin
                    rd_fire = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gate with reset so the stall drops immediately even if IF keeps en high.
    assign inst_sram_stallreq = stall_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            cnt_q            <= 4'd0;
            lat_idx_q        <= '0;
            lat_rng_q        <= 1'b0;
            inst_sram_rdata  <= 32'h0;
            inst_sram_rvalid <= 1'b0;
            inst_sram_err    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            lat_idx_q        <= lat_idx_d;
            lat_rng_q        <= lat_rng_d;
            inst_sram_rvalid <= rd_fire;
            inst_sram_err    <= (rd_fire & ~rd_rng) | (wr_fire & (~WRITE_EN | ~in_range));
            if (rd_fire) begin
                inst_sram_rdata <= rd_rng ? mem[rd_idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (WRITE_EN && wr_fire && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/inst_sram_resp.md
# inst_sram_resp

Instruction-side SRAM responder. It serves the fetch requests that the IF stage drives on the `inst_sram_*` interface, from an on-chip word-organised array. It supports a configurable number of wait states, and raises a stall request to the pipeline controller while a fetch is outstanding. It sits between IF/ID and the pipeline controller, in place of the external instruction SRAM, for bring-up and simulation.

## Interface
Parameters:
- `ADDR_W`, default 12: word-index width; array depth is 2^ADDR_W words.
- `WAIT_CYC`, default 0: wait states per read. Legal range is 0..15.
- `BASE_PADDR`, default 32'h1FC0_0000: physical byte address of word 0.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_sram_en`  in  1  request enable from IF.
- `inst_sram_wen`  in  4  byte write enables; 4'b0000 means read.
- `inst_sram_addr`  in  32  virtual byte address.
- `inst_sram_wdata`  in  32  write data.
- `inst_sram_rdata`  out  32  registered read data.
- `inst_sram_rvalid`  out  1  one-cycle pulse marking new `rdata`.
- `inst_sram_stallreq`  out  1  stall request to the pipeline controller (maps to the IF stall bit).
- `inst_sram_err`  out  1  one-cycle pulse on an out-of-range or illegal access.

## Operation
Address translation:
- `paddr = {3'b000, inst_sram_addr[28:0]}`, which strips the kseg0/kseg1 segment bits.
- `offs = paddr - BASE_PADDR`, computed in 32 bits.
- An access is in range when `offs[31:ADDR_W+2] == 0`.
- Word index is `offs[ADDR_W+1:2]`. `addr[1:0]` is ignored.

FSM states:
- **IDLE**
  - With `en=1` and `wen=0`:
    - If `WAIT_CYC==0`: read the array, register the result into `rdata`, assert `rvalid` next cycle, stay in IDLE.
    - Otherwise: latch the word index and range flag, load `cnt <= WAIT_CYC-1`, go to WAIT.
  - With `en=1` and `wen!=0`: write handling (see Configuration). Completes in one cycle, no wait states; `rdata` and `rvalid` are unaffected.
  - With `en=0`: no action; `rdata` holds its value.
- **WAIT**
  - Inputs are ignored; the latched address is used.
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: perform the read, register `rdata`, pulse `rvalid` next cycle, return to IDLE.

Other rules:
- `stallreq` is combinational: `(IDLE & en & ~|wen & WAIT_CYC!=0) | (WAIT & cnt!=0)`.
- Out-of-range read: `rdata <= 32'h0`, `rvalid` still pulses, and `err` pulses in the same cycle as `rvalid`.
- Out-of-range write: array unchanged, `err` pulses the next cycle.
- Only one read is in flight at a time.
- Reset values: `rdata=0`, `rvalid=0`, `err=0`, state IDLE, `cnt=0`, so `stallreq=0`. Array contents are not reset.
- Reset asserted in WAIT drops the pending read. No `rvalid` is produced for it, and `stallreq` falls immediately on reset (asynchronous).

## Timing
- `WAIT_CYC=0`: request in cycle N → `rdata`/`rvalid` in cycle N+1; `stallreq` is never asserted.
- `WAIT_CYC=K>0`: request accepted in cycle N:
  - `stallreq` is high in cycles N..N+K-1 and low in N+K.
  - `rdata`/`rvalid` appear in cycle N+K+1.
  - The earliest next accept is cycle N+K+1 (IDLE).
- A request with `en=1` during a WAIT cycle is not accepted and leaves no side effect. IF holds `addr` stable while stalled, so this case arises only on misuse.
- A write in IDLE in cycle N is visible to a read issued in cycle N+1.
- Read and write to the same word in the same cycle cannot occur, because a request is either a read or a write.

## Configuration
`INST_SRAM_WRITE_EN`:
- Defined: writes are honoured per byte lane. `wen[i]` writes `wdata[8i+7:8i]` into the addressed word.
- Undefined: no write port is synthesised, every request with `wen!=0` is dropped, and `err` pulses the next cycle. Read behaviour is identical in both builds.

## Test plan
- Reset release, `WAIT_CYC=0`, array word 0 = 32'h3C08_BFC0, `en=1`, `addr=32'hBFC0_0000` → `rdata=32'h3C08_BFC0`, `rvalid=1` next cycle, `stallreq` always 0.
- `WAIT_CYC=3`, read `addr=32'h9FC0_0004` (kseg0 alias of word 1) → `stallreq` high for exactly 3 cycles, `rdata` = word 1 in cycle N+4, `rvalid` single pulse.
- Read `addr=32'hBFBF_FFFC` (below base) → `rdata=0`, `rvalid=1`, `err=1` in the same cycle, no array change.
- `INST_SRAM_WRITE_EN` defined: write `wen=4'b0011`, `wdata=32'hAAAA_5555` to a word holding 32'h1234_5678, then read it → 32'h1234_5555. Undefined: same write → `err` pulse, read returns 32'h1234_5678.
- `WAIT_CYC=2`: assert `rst` one cycle after accept → `stallreq`, `rvalid`, `err` all 0 immediately, no late `rvalid`, next read after reset returns correct data.
- Back-to-back reads to words 0,1,2 with `WAIT_CYC=0` → `rvalid` high three consecutive cycles carrying words 0,1,2 in order.
